// File: rtl/ssram_pkg.sv
// Shared constants and types for the synchronous-SRAM responder.
//   BURST_LEN  : words per linear burst block (address wraps inside it)
//   BURST_W    : address bits that wrap during a burst
//   RD_LATENCY : edges from read start to data on dq_out
//   state_e    : burst-direction state encoding
//   burst_wrap_inc : next in-block burst offset (wraps naturally)
package ssram_pkg;

  localparam int unsigned BURST_LEN  = 4;
  localparam int unsigned BURST_W    = $clog2(BURST_LEN);
  localparam int unsigned RD_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } state_e;

  function automatic logic [BURST_W-1:0] burst_wrap_inc(input logic [BURST_W-1:0] ofs);
    return ofs + BURST_W'(1);
  endfunction

endpackage

// File: rtl/ssram_resp_mem.sv
// Byte-enabled storage array for the SSRAM responder.
// One synchronous write port (per-byte enables, active-high) and one
// registered read port. Contents are not reset.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write word address
//   wr_be    : byte enables, active-high
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates on the edge it is sampled
//   rd_addr  : read word address
//   rd_data  : registered read data (holds when rd_en=0)
module ssram_resp_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ssram_responder.sv
// Synchronous pipelined burst SRAM slave model (responder side).
// Starts (ce_n=0, adsc_n=0) latch address and direction; advance edges
// (adsc_n=1, adv_n=0) step a 4-word wrapping burst. Reads return data
// RD_LATENCY edges after they are sampled; a write sampled while read data
// is still in flight cancels that data and flags a protocol error.
//   clk, reset        : clock, asynchronous active-high reset
//   ssram_ce_n        : chip select (active-low)
//   ssram_adsc_n      : address strobe / start (active-low)
//   ssram_adv_n       : burst advance (active-low)
//   ssram_we_n        : write (active-low), sampled at start
//   ssram_oe_n        : output enable (active-low), gates dq_oe
//   ssram_be_n        : byte enables (active-low)
//   ssram_addr        : word address
//   dq_in / dq_out    : write data in / read data out
//   dq_oe             : drive enable for dq_out
//   protocol_err      : sticky protocol-violation flag
module ssram_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ssram_ce_n,
  input  logic                ssram_adsc_n,
  input  logic                ssram_adv_n,
  input  logic                ssram_we_n,
  input  logic                ssram_oe_n,
  input  logic [DATA_W/8-1:0] ssram_be_n,
  input  logic [ADDR_W-1:0]   ssram_addr,
  input  logic [DATA_W-1:0]   dq_in,
  output logic [DATA_W-1:0]   dq_out,
  output logic                dq_oe,
  output logic                protocol_err
);

  import ssram_pkg::*;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_rd, acc_wr, adv_idle_err;
  logic [RD_LATENCY:0] rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic [DATA_W-1:0]   mem_rdata;
  logic                perr_q, perr_d;
  logic                start, adv;

  // adsc_n takes precedence over adv_n
  assign start = ~ssram_ce_n & ~ssram_adsc_n;
  assign adv   = ~ssram_ce_n &  ssram_adsc_n & ~ssram_adv_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ssram_we_n ? ST_RD_BURST : ST_WR_BURST;
    end else if (ssram_ce_n) begin
      state_d = ST_IDLE;
    end
  end

  // Access decode for this edge: which address (if any) is read or written.
  always_comb begin
    acc_rd       = 1'b0;
    acc_wr       = 1'b0;
    acc_addr     = baddr_q;
    baddr_d      = baddr_q;
    adv_idle_err = 1'b0;
    if (start) begin
      acc_addr = ssram_addr;
      baddr_d  = ssram_addr;
      acc_wr   = ~ssram_we_n;
      acc_rd   = ssram_we_n;
    end else if (adv) begin
      if (state_q == ST_IDLE) begin
        adv_idle_err = 1'b1;
      end else begin
        acc_addr = {baddr_q[ADDR_W-1:BURST_W], burst_wrap_inc(baddr_q[BURST_W-1:0])};
        baddr_d  = acc_addr;
        acc_wr   = (state_q == ST_WR_BURST);
        acc_rd   = (state_q == ST_RD_BURST);
      end
    end
  end

  // rd_vld bit 0: request captured; bit 1: memory data registered;
  // bit RD_LATENCY: data on dq_out. A write flushes every stage below the
  // output, so reads not yet presented are never driven.
  always_comb begin
    rd_vld_d  = acc_wr ? '0 : {rd_vld_q[RD_LATENCY-1:0], acc_rd};
    rd_addr_d = acc_rd ? acc_addr : rd_addr_q;
    dq_out_d  = rd_vld_d[RD_LATENCY] ? mem_rdata : dq_out_q;
    perr_d    = perr_q | adv_idle_err | (acc_wr & (|rd_vld_q[RD_LATENCY-1:0]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baddr_q   <= '0;
      rd_vld_q  <= '0;
      rd_addr_q <= '0;
      dq_out_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      baddr_q   <= baddr_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      dq_out_q  <= dq_out_d;
      perr_q    <= perr_d;
    end
  end

  ssram_resp_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (acc_wr),
    .wr_addr (acc_addr),
    .wr_be   (~ssram_be_n),
    .wr_data (dq_in),
    .rd_en   (rd_vld_q[0]),
    .rd_addr (rd_addr_q),
    .rd_data (mem_rdata)
  );

  assign dq_out       = dq_out_q;
  assign dq_oe        = rd_vld_q[RD_LATENCY] & ~ssram_oe_n;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_ssram_responder.sv
// Scoreboard bench for ssram_responder: a transaction-level model turns each
// sampled bus cycle into expected read deliveries (queued with the edge they
// are due); a negedge monitor pops and compares against dq_oe/dq_out and the
// sticky error flag. Directed scenarios check literal values on top.
module tb_ssram_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk       = 1'b0;
  logic          reset_i   = 1'b1;
  logic          ce_n_i    = 1'b1;
  logic          adsc_n_i  = 1'b1;
  logic          adv_n_i   = 1'b1;
  logic          we_n_i    = 1'b1;
  logic          oe_n_i    = 1'b0;
  logic [3:0]    be_n_i    = 4'hF;
  logic [AW-1:0] addr_i    = '0;
  logic [DW-1:0] dq_in_i   = '0;
  logic [DW-1:0] dq_out;
  logic          dq_oe;
  logic          protocol_err;

  ssram_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset_i),
    .ssram_ce_n   (ce_n_i),
    .ssram_adsc_n (adsc_n_i),
    .ssram_adv_n  (adv_n_i),
    .ssram_we_n   (we_n_i),
    .ssram_oe_n   (oe_n_i),
    .ssram_be_n   (be_n_i),
    .ssram_addr   (addr_i),
    .dq_in        (dq_in_i),
    .dq_out       (dq_out),
    .dq_oe        (dq_oe),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } exp_t;
  typedef struct { int e;   logic [31:0] d;    } dlv_t;

  logic [31:0] mem_m [256];
  exp_t        exp_q [$];
  dlv_t        dlv_q [$];
  logic [31:0] lit_q [$];
  int unsigned m_mode;    // 0 none, 1 read burst, 2 write burst
  int unsigned m_baddr;
  logic        m_perr;
  logic [31:0] m_last;
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_mode  = 0;
    m_baddr = 0;
    m_perr  = 1'b0;
    m_last  = '0;
  endtask

  task automatic model_access(input int unsigned a, input bit wr, input int m);
    if (wr) begin
      if (exp_q.size() != 0) m_perr = 1'b1;
      exp_q.delete();
      for (int b = 0; b < 4; b++)
        if (!be_n_i[b]) mem_m[a][8*b +: 8] = dq_in_i[8*b +: 8];
    end else begin
      exp_q.push_back('{due: m + 2, data: mem_m[a]});
    end
  endtask

  task automatic model_step();
    int m;
    m = edge_cnt;
    if (reset_i) begin
      model_clear();
      return;
    end
    if (!ce_n_i && !adsc_n_i) begin
      m_mode  = we_n_i ? 1 : 2;
      m_baddr = addr_i;
      model_access(m_baddr, !we_n_i, m);
    end else if (!ce_n_i && !adv_n_i) begin
      if (m_mode == 0) m_perr = 1'b1;
      else begin
        m_baddr = (m_baddr & 32'hFC) | ((m_baddr + 1) & 32'h3);
        model_access(m_baddr, m_mode == 2, m);
      end
    end else if (ce_n_i) begin
      m_mode = 0;
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_step();
  end

  // Monitor: one delivery due per edge at most.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      exp_v  = 1'b1;
      m_last = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("dq_oe", {31'b0, dq_oe}, {31'b0, exp_v & ~oe_n_i});
    chk("dq_out", dq_out, m_last);
    chk("protocol_err", {31'b0, protocol_err}, {31'b0, m_perr});
    if (dq_oe === 1'b1) dlv_q.push_back('{e: edge_cnt, d: dq_out});
  end

  task automatic cyc(input logic ce, input logic adsc, input logic adv, input logic we,
                     input logic oe, input logic [3:0] be, input logic [7:0] a,
                     input logic [31:0] d);
    ce_n_i = ce; adsc_n_i = adsc; adv_n_i = adv; we_n_i = we;
    oe_n_i = oe; be_n_i = be; addr_i = a; dq_in_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic oe);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, oe, 4'hF, 8'h00, 32'h0);
  endtask

  task automatic do_reset();
    ce_n_i = 1'b1; adsc_n_i = 1'b1; adv_n_i = 1'b1; we_n_i = 1'b1; oe_n_i = 1'b0;
    reset_i = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Deliveries recorded since dlv_q was cleared must equal lit_q, on
  // consecutive edges starting RD_LATENCY after start_edge.
  task automatic check_dlv(input string name, input int start_edge);
    chk({name, " count"}, dlv_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < dlv_q.size(); i++) begin
      chk({name, " data"}, dlv_q[i].d, lit_q[i]);
      chk({name, " edge"}, dlv_q[i].e, start_edge + 2 + i);
    end
  endtask

  initial begin
    int st;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;

    for (int a = 0; a < 256; a++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'(a), $urandom);
    idle(1'b0);

    // single write then read
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h10, 32'hDEADBEEF);
    idle(1'b0);
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    st = edge_cnt;
    repeat (4) idle(1'b0);
    lit_q = '{32'hDEADBEEF};
    check_dlv("single_rd", st);

    // byte enables
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h20, 32'hFFFFFFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 8'h20, 32'h00000000);
    idle(1'b0);
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    st = edge_cnt;
    repeat (4) idle(1'b0);
    lit_q = '{32'hFF00FF00};
    check_dlv("byte_en", st);

    // burst write 0x04..0x07, wrapped burst read from 0x06
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h04, 32'hA0A00000);
    for (int i = 1; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'hA0A00000 + 32'(i));
    idle(1'b0);
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h06, 32'h0);
    st = edge_cnt;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
    repeat (4) idle(1'b0);
    lit_q = '{32'hA0A00002, 32'hA0A00003, 32'hA0A00000, 32'hA0A00001};
    check_dlv("burst_wrap", st);

    // output-enable gating
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 8'h10, 32'h0);
    st = edge_cnt;
    repeat (4) idle(1'b1);
    lit_q.delete();
    check_dlv("oe_gate", st);
    chk("oe_gate perr", {31'b0, protocol_err}, 32'd0);

    // reset one edge after a read start
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h30, 32'h12345678);
    idle(1'b0);
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h30, 32'h0);
    idle(1'b0);
    do_reset();
    repeat (2) idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h30, 32'h0);
    st = edge_cnt;
    repeat (4) idle(1'b0);
    lit_q = '{32'h12345678};
    check_dlv("reset_mid_rd", st);

    // read followed immediately by a write
    dlv_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    st = edge_cnt;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'h11, 32'h0);
    repeat (4) idle(1'b0);
    lit_q.delete();
    check_dlv("turnaround", st);
    chk("turnaround perr", {31'b0, protocol_err}, 32'd1);

    // advance while idle
    do_reset();
    idle(1'b0);
    dlv_q.delete();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
    st = edge_cnt;
    repeat (4) idle(1'b0);
    check_dlv("adv_idle", st);
    chk("adv_idle perr", {31'b0, protocol_err}, 32'd1);

    // randomized segments, each from reset so the sticky flag stays useful
    for (int s = 0; s < 20; s++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        int unsigned r;
        logic oe;
        r  = $urandom_range(0, 99);
        oe = ($urandom_range(0, 9) == 0);
        if (r < 12)
          cyc(1'b1, 1'($urandom), 1'b1, 1'($urandom), oe, 4'($urandom), 8'($urandom), $urandom);
        else if (r < 37)
          cyc(1'b0, 1'b0, 1'($urandom), 1'b1, oe, 4'($urandom), 8'($urandom), $urandom);
        else if (r < 52)
          cyc(1'b0, 1'b0, 1'($urandom), 1'b0, oe, 4'($urandom), 8'($urandom), $urandom);
        else if (r < 80)
          cyc(1'b0, 1'b1, 1'b0, 1'($urandom), oe, 4'($urandom), 8'($urandom), $urandom);
        else
          cyc(1'b0, 1'b1, 1'b1, 1'($urandom), oe, 4'($urandom), 8'($urandom), $urandom);
      end
      repeat (4) idle(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
